can_frame_receiver: RTL and testbench



---
 rtl/can_frame_receiver.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_can_frame_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_receiver.sv
// Standard-format CAN frame receiver: bus-idle sync, SOF detect, destuffing, field extraction, ACK drive.
// Optional CRC-15 check is compiled in when CAN_RX_CRC_CHECK_EN is defined.
module can_frame_receiver #(
  parameter int IDLE_BITS = 11,
  parameter int MAX_BYTES = 8
) (
  input  logic        can_clk,
  input  logic        reset,
  input  logic        can_hi_in,
  input  logic        can_lo_in,
  output logic        ack_drive,
  output logic        busy,
  output logic        frame_valid,
  output logic [10:0] rx_id,
  output logic [1:0]  rx_ctrl,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic [14:0] rx_crc,
  output logic        rx_error,
  output logic [1:0]  err_code
);
  typedef enum logic [3:0] {
    SYNC, IDLE, ID, CTRL, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
  } state_t;

  localparam int             IW        = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_BITS - 1);
  localparam logic [3:0]     MAX_B     = 4'(MAX_BYTES);

  state_t        state_reg, state_next;
  logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [6:0]    bit_cnt_reg, bit_cnt_next;
  logic [2:0]    run_len_reg, run_len_next;
  logic          run_val_reg, run_val_next;
  logic [10:0]   id_sh_reg, id_sh_next;
  logic [1:0]    ctrl_sh_reg, ctrl_sh_next;
  logic [3:0]    dlc_sh_reg, dlc_sh_next;
  logic [63:0]   data_sh_reg, data_sh_next;
  logic [14:0]   crc_sh_reg, crc_sh_next;
  logic          ack_reg, ack_next;
  logic          fv_reg, fv_next;
  logic          err_reg, err_next;
  logic [1:0]    code_reg, code_next;
  logic [10:0]   rx_id_reg, rx_id_next;
  logic [1:0]    rx_ctrl_reg, rx_ctrl_next;
  logic [3:0]    rx_dlc_reg, rx_dlc_next;
  logic [63:0]   rx_data_reg, rx_data_next;
  logic [14:0]   rx_crc_reg, rx_crc_next;

  logic          in_frame, destuff, take_bit, field_last;
  logic          bus_err, stuff_err, form_err, crc_err;
  logic [6:0]    field_len;
  logic [5:0]    data_idx;

`ifdef CAN_RX_CRC_CHECK_EN
  logic [14:0]   crc_calc_reg, crc_calc_next;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction
`endif

  // Data field length in bits; DLC values above MAX_BYTES are clamped.
  function automatic logic [6:0] field_bits(input logic [3:0] dlc);
    logic [3:0] n;
    n = (dlc > MAX_B) ? MAX_B : dlc;
    field_bits = {n, 3'b000};
  endfunction

  always_ff @(posedge can_clk) begin
    if (reset) begin
      state_reg    <= SYNC;
      idle_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      run_len_reg  <= '0;
      run_val_reg  <= 1'b0;
      id_sh_reg    <= '0;
      ctrl_sh_reg  <= '0;
      dlc_sh_reg   <= '0;
      data_sh_reg  <= '0;
      crc_sh_reg   <= '0;
      ack_reg      <= 1'b0;
      fv_reg       <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= '0;
      rx_id_reg    <= '0;
      rx_ctrl_reg  <= '0;
      rx_dlc_reg   <= '0;
      rx_data_reg  <= '0;
      rx_crc_reg   <= '0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_calc_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      run_len_reg  <= run_len_next;
      run_val_reg  <= run_val_next;
      id_sh_reg    <= id_sh_next;
      ctrl_sh_reg  <= ctrl_sh_next;
      dlc_sh_reg   <= dlc_sh_next;
      data_sh_reg  <= data_sh_next;
      crc_sh_reg   <= crc_sh_next;
      ack_reg      <= ack_next;
      fv_reg       <= fv_next;
      err_reg      <= err_next;
      code_reg     <= code_next;
      rx_id_reg    <= rx_id_next;
      rx_ctrl_reg  <= rx_ctrl_next;
      rx_dlc_reg   <= rx_dlc_next;
      rx_data_reg  <= rx_data_next;
      rx_crc_reg   <= rx_crc_next;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_calc_reg <= crc_calc_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    run_len_next  = run_len_reg;
    run_val_next  = run_val_reg;
    id_sh_next    = id_sh_reg;
    ctrl_sh_next  = ctrl_sh_reg;
    dlc_sh_next   = dlc_sh_reg;
    data_sh_next  = data_sh_reg;
    crc_sh_next   = crc_sh_reg;
    ack_next      = 1'b0;
    fv_next       = 1'b0;
    err_next      = 1'b0;
    code_next     = code_reg;
    rx_id_next    = rx_id_reg;
    rx_ctrl_next  = rx_ctrl_reg;
    rx_dlc_next   = rx_dlc_reg;
    rx_data_next  = rx_data_reg;
    rx_crc_next   = rx_crc_reg;
`ifdef CAN_RX_CRC_CHECK_EN
    crc_calc_next = crc_calc_reg;
`endif
    bus_err   = 1'b0;
    stuff_err = 1'b0;
    form_err  = 1'b0;
    crc_err   = 1'b0;
    take_bit  = 1'b0;
    in_frame  = !(state_reg == SYNC || state_reg == IDLE);
    // A run of five ending on the last CRC bit still owes a stuff bit before the delimiter.
    destuff   = (state_reg inside {ID, CTRL, DLC, DATA, CRC}) ||
                (state_reg == CRC_DEL && run_len_reg == 3'd5);
    data_idx  = 6'(7'd63 - bit_cnt_reg);

    case (state_reg)
      ID:      field_len = 7'd11;
      CTRL:    field_len = 7'd2;
      DLC:     field_len = 7'd4;
      DATA:    field_len = field_bits(dlc_sh_reg);
      CRC:     field_len = 7'd15;
      EOF:     field_len = 7'd7;
      default: field_len = 7'd1;
    endcase
    field_last = (bit_cnt_reg == field_len - 7'd1);

    if (in_frame) begin
      bus_err = (can_hi_in == can_lo_in);
      if (destuff && run_len_reg == 3'd5) begin
        stuff_err    = (can_lo_in == run_val_reg);
        run_len_next = 3'd1;
        run_val_next = can_lo_in;
      end else begin
        take_bit = 1'b1;
        bit_cnt_next = field_last ? 7'd0 : bit_cnt_reg + 7'd1;
        if (destuff) begin
          if (can_lo_in == run_val_reg) begin
            run_len_next = run_len_reg + 3'd1;
          end else begin
            run_len_next = 3'd1;
            run_val_next = can_lo_in;
          end
        end
      end
    end

`ifdef CAN_RX_CRC_CHECK_EN
    if (take_bit && (state_reg inside {ID, CTRL, DLC, DATA}))
      crc_calc_next = crc_step(crc_calc_reg, can_lo_in);
`endif

    case (state_reg)
      SYNC: begin
        if (can_lo_in) begin
          if (idle_cnt_reg == IDLE_LAST) begin
            state_next    = IDLE;
            idle_cnt_next = '0;
          end else begin
            idle_cnt_next = idle_cnt_reg + IW'(1);
          end
        end else begin
          idle_cnt_next = '0;
        end
      end
      IDLE: begin
        if (!can_lo_in) begin
          state_next   = ID;
          bit_cnt_next = '0;
          run_len_next = 3'd1;
          run_val_next = 1'b0;
          id_sh_next   = '0;
          ctrl_sh_next = '0;
          dlc_sh_next  = '0;
          data_sh_next = '0;
          crc_sh_next  = '0;
`ifdef CAN_RX_CRC_CHECK_EN
          crc_calc_next = '0;
`endif
        end
      end
      ID: if (take_bit) begin
        id_sh_next = {id_sh_reg[9:0], can_lo_in};
        if (field_last) state_next = CTRL;
      end
      CTRL: if (take_bit) begin
        ctrl_sh_next = {ctrl_sh_reg[0], can_lo_in};
        if (field_last) state_next = DLC;
      end
      DLC: if (take_bit) begin
        dlc_sh_next = {dlc_sh_reg[2:0], can_lo_in};
        if (field_last)
          state_next = (field_bits({dlc_sh_reg[2:0], can_lo_in}) == 7'd0) ? CRC : DATA;
      end
      DATA: if (take_bit) begin
        data_sh_next[data_idx] = can_lo_in;
        if (field_last) state_next = CRC;
      end
      CRC: if (take_bit) begin
        crc_sh_next = {crc_sh_reg[13:0], can_lo_in};
        if (field_last) state_next = CRC_DEL;
      end
      CRC_DEL: if (take_bit) begin
        if (!can_lo_in) form_err = 1'b1;
`ifdef CAN_RX_CRC_CHECK_EN
        else if (crc_sh_reg != crc_calc_reg) crc_err = 1'b1;
`endif
        state_next = ACK;
        ack_next   = 1'b1;
      end
      ACK: state_next = ACK_DEL;
      ACK_DEL: begin
        if (!can_lo_in) form_err = 1'b1;
        state_next = EOF;
      end
      EOF: begin
        if (!can_lo_in) begin
          form_err = 1'b1;
        end else if (field_last) begin
          state_next   = IDLE;
          fv_next      = 1'b1;
          rx_id_next   = id_sh_reg;
          rx_ctrl_next = ctrl_sh_reg;
          rx_dlc_next  = dlc_sh_reg;
          rx_data_next = data_sh_reg;
          rx_crc_next  = crc_sh_reg;
        end
      end
      default: state_next = SYNC;
    endcase

    if (bus_err || stuff_err || form_err || crc_err) begin
      state_next    = SYNC;
      idle_cnt_next = '0;
      err_next      = 1'b1;
      ack_next      = 1'b0;
      fv_next       = 1'b0;
      rx_id_next    = rx_id_reg;
      rx_ctrl_next  = rx_ctrl_reg;
      rx_dlc_next   = rx_dlc_reg;
      rx_data_next  = rx_data_reg;
      rx_crc_next   = rx_crc_reg;
      if (bus_err)        code_next = 2'd3;
      else if (stuff_err) code_next = 2'd0;
      else if (form_err)  code_next = 2'd2;
      else                code_next = 2'd1;
    end
  end

  assign busy        = !(state_reg == SYNC || state_reg == IDLE);
  assign ack_drive   = ack_reg;
  assign frame_valid = fv_reg;
  assign rx_error    = err_reg;
  assign err_code    = code_reg;
  assign rx_id       = rx_id_reg;
  assign rx_ctrl     = rx_ctrl_reg;
  assign rx_dlc      = rx_dlc_reg;
  assign rx_data     = rx_data_reg;
  assign rx_crc      = rx_crc_reg;
endmodule

// File: tb/tb_can_frame_receiver.sv
// Scoreboard bench for can_frame_receiver: encodes stuffed frames, queues expected results, checks pulses.
// Honours CAN_RX_CRC_CHECK_EN for the corrupted-CRC expectation.
module tb_can_frame_receiver;
  logic        can_clk = 1'b0;
  logic        reset = 1'b1;
  logic        can_hi_in = 1'b0;
  logic        can_lo_in = 1'b1;
  logic        ack_drive, busy, frame_valid, rx_error;
  logic [10:0] rx_id;
  logic [1:0]  rx_ctrl, err_code;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [14:0] rx_crc;

  can_frame_receiver dut (
    .can_clk(can_clk), .reset(reset), .can_hi_in(can_hi_in), .can_lo_in(can_lo_in),
    .ack_drive(ack_drive), .busy(busy), .frame_valid(frame_valid),
    .rx_id(rx_id), .rx_ctrl(rx_ctrl), .rx_dlc(rx_dlc), .rx_data(rx_data),
    .rx_crc(rx_crc), .rx_error(rx_error), .err_code(err_code)
  );

  always #5 can_clk = ~can_clk;

  localparam logic [1:0] REC = 2'b01, DOM = 2'b10;
  localparam int M_OK = 0, M_IGN = 1, M_CRCFLIP = 2, M_DELDOM = 3,
                 M_EOFDOM = 4, M_BUS = 5, M_STUFF = 6, M_RESET = 7;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [10:0] id;
    logic [1:0]  ctrl;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt;
  logic [10:0] last_id = '0;
  logic [63:0] last_data = '0;
  logic [1:0]  sq[$];
  int          data_start, first_stuff;
  logic [14:0] crc_sent;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] crc_next(input logic [14:0] c, input bit b);
    logic [14:0] r;
    r = {c[13:0], 1'b0};
    if (b ^ c[14]) r = r ^ 15'h4599;
    return r;
  endfunction

  function automatic int nbytes(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 8 : int'(dlc);
  endfunction

  function automatic logic [63:0] mask_data(input logic [63:0] data, input logic [3:0] dlc);
    logic [63:0] m;
    m = data;
    for (int i = 8 * nbytes(dlc); i < 64; i++) m[63 - i] = 1'b0;
    return m;
  endfunction

  // Destuffed SOF..CRC bit list, then bit-stuffed into bus symbols {hi, lo}.
  task automatic build(input logic [10:0] id, input logic [1:0] ctrl, input logic [3:0] dlc,
                       input logic [63:0] data, input bit flip);
    bit d[$];
    logic [14:0] c;
    int run;
    bit val;
    d.push_back(1'b0);
    for (int i = 10; i >= 0; i--) d.push_back(id[i]);
    for (int i = 1; i >= 0; i--)  d.push_back(ctrl[i]);
    for (int i = 3; i >= 0; i--)  d.push_back(dlc[i]);
    for (int i = 0; i < 8 * nbytes(dlc); i++) d.push_back(data[63 - i]);
    c = '0;
    foreach (d[i]) c = crc_next(c, d[i]);
    if (flip) c[0] = ~c[0];
    crc_sent = c;
    for (int i = 14; i >= 0; i--) d.push_back(c[i]);
    sq.delete();
    run = 0;
    val = 1'b0;
    first_stuff = -1;
    data_start = -1;
    foreach (d[i]) begin
      if (i == 18) data_start = sq.size();
      sq.push_back(d[i] ? REC : DOM);
      if (run > 0 && d[i] == val) run++;
      else begin
        val = d[i];
        run = 1;
      end
      if (run == 5) begin
        if (first_stuff < 0) first_stuff = sq.size();
        sq.push_back(val ? DOM : REC);
        val = ~val;
        run = 1;
      end
    end
  endtask

  task automatic send_sym(input logic [1:0] s);
    can_hi_in = s[1];
    can_lo_in = s[0];
    @(posedge can_clk);
    #1;
    if (ack_drive) ack_cnt++;
  endtask

  task automatic run_frame(input logic [10:0] id, input logic [1:0] ctrl, input logic [3:0] dlc,
                           input logic [63:0] data, input int mode, input int pre_idle);
    exp_t e;
    bit push, exp_ack, stop;
    logic [1:0] s;
    build(id, ctrl, dlc, data, mode == M_CRCFLIP);
    e.is_err = 1'b0; e.code = 2'd0; e.id = id; e.ctrl = ctrl; e.dlc = dlc;
    e.data = mask_data(data, dlc); e.crc = crc_sent;
    push = 1'b1;
    exp_ack = 1'b0;
    case (mode)
      M_OK:      exp_ack = 1'b1;
      M_IGN:     push = 1'b0;
      M_RESET:   push = 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      M_CRCFLIP: begin e.is_err = 1'b1; e.code = 2'd1; end
`else
      M_CRCFLIP: exp_ack = 1'b1;
`endif
      M_DELDOM:  begin e.is_err = 1'b1; e.code = 2'd2; end
      M_EOFDOM:  begin e.is_err = 1'b1; e.code = 2'd2; exp_ack = 1'b1; end
      M_BUS:     begin e.is_err = 1'b1; e.code = 2'd3; end
      M_STUFF:   begin e.is_err = 1'b1; e.code = 2'd0; sq.delete(first_stuff); end
      default:   push = 1'b0;
    endcase
    repeat (pre_idle) send_sym(REC);
    if (push) sb.push_back(e);
    ack_cnt = 0;
    stop = 1'b0;
    for (int i = 0; i < sq.size() && !stop; i++) begin
      s = sq[i];
      if (mode == M_BUS && i == data_start) s = 2'b11;
      if (mode == M_RESET && i == data_start + 3) begin
        reset = 1'b1;
        send_sym(REC);
        reset = 1'b0;
        check("reset_ctrl_outs", {ack_drive, busy, frame_valid, rx_error, err_code,
                                  rx_id, rx_ctrl, rx_dlc, rx_crc}, 64'd0);
        check("reset_rx_data", rx_data, 64'd0);
        last_id = '0;
        last_data = '0;
        stop = 1'b1;
      end else begin
        send_sym(s);
        if (i == 0) check("busy_after_sof", busy, (mode == M_IGN) ? 64'd0 : 64'd1);
        if (mode == M_STUFF && i == first_stuff) stop = 1'b1;
      end
    end
    if (!stop) begin
      send_sym((mode == M_DELDOM) ? DOM : REC);
      check("ack_slot", ack_drive, exp_ack);
      send_sym(ack_drive ? DOM : REC);
      send_sym(REC);
      for (int k = 0; k < 7; k++) send_sym((mode == M_EOFDOM && k == 3) ? DOM : REC);
      if (push && !e.is_err) check("valid_timing", frame_valid, 64'd1);
      repeat (3) send_sym(REC);
    end
    check("ack_count", ack_cnt, exp_ack);
  endtask

  always @(negedge can_clk) begin
    if (frame_valid || rx_error) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {frame_valid, rx_error}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {frame_valid, rx_error}, mon_e.is_err ? 64'd1 : 64'd2);
        if (mon_e.is_err) begin
          check("err_code", err_code, mon_e.code);
          check("hold_id", rx_id, last_id);
          check("hold_data", rx_data, last_data);
          $display("rx error: code=%0d expected=%0d", err_code, mon_e.code);
        end else begin
          check("rx_id", rx_id, mon_e.id);
          check("rx_ctrl", rx_ctrl, mon_e.ctrl);
          check("rx_dlc", rx_dlc, mon_e.dlc);
          check("rx_data", rx_data, mon_e.data);
          check("rx_crc", rx_crc, mon_e.crc);
          check("busy_at_valid", busy, 64'd0);
          last_id = mon_e.id;
          last_data = mon_e.data;
          $display("rx frame: id=%h ctrl=%0d dlc=%h data=%h crc=%h", rx_id, rx_ctrl, rx_dlc, rx_data, rx_crc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge can_clk);
    #1;
    reset = 1'b0;
    check("reset_ctrl_outs", {ack_drive, busy, frame_valid, rx_error, err_code,
                              rx_id, rx_ctrl, rx_dlc, rx_crc}, 64'd0);
    check("reset_rx_data", rx_data, 64'd0);

    run_frame(11'h7F8, 2'd0, 4'd1, 64'h8900_0000_0000_0000, M_OK, 11);
    run_frame(11'h7FF, 2'd0, 4'd0, 64'd0, M_OK, 0);
    run_frame(11'h7FF, 2'd0, 4'd0, 64'd0, M_STUFF, 0);
    run_frame(11'h123, 2'd1, 4'd2, 64'hABCD_0000_0000_0000, M_IGN, 3);
    run_frame(11'h2A5, 2'd1, 4'd2, 64'hDEAD_0000_0000_0000, M_OK, 0);
    run_frame(11'h155, 2'd2, 4'd3, 64'h1234_5600_0000_0000, M_CRCFLIP, 0);
    run_frame(11'h0F0, 2'd0, 4'd1, 64'h5A00_0000_0000_0000, M_DELDOM, 11);
    run_frame(11'h00F, 2'd3, 4'd1, 64'hC300_0000_0000_0000, M_EOFDOM, 11);
    run_frame(11'h3C3, 2'd0, 4'd2, 64'h7777_0000_0000_0000, M_BUS, 11);
    run_frame(11'h001, 2'd0, 4'hF, 64'h0102_0304_0506_0708, M_OK, 11);
    run_frame(11'h400, 2'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, M_OK, 0);
    for (int n = 0; n < 6; n++)
      run_frame(11'($urandom), 2'($urandom), 4'($urandom_range(0, 15)),
                {$urandom, $urandom}, M_OK, 0);
    run_frame(11'h5A5, 2'd0, 4'd4, 64'h1122_3344_0000_0000, M_RESET, 0);
    run_frame(11'h6B6, 2'd0, 4'd1, 64'h9900_0000_0000_0000, M_IGN, 4);
    run_frame(11'h246, 2'd1, 4'd2, 64'hBEEF_0000_0000_0000, M_OK, 0);

    repeat (5) send_sym(REC);
    check("scoreboard_drain", sb.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
